// File: rtl/decode_wb_param.sv
// Decode / write-back stage: NREG-entry register file, textbook forwarding, load/use detect, D->E register.
// Optional DECODE_PERF_CNT_EN adds fwd_cnt / bubble_cnt performance counters.
module decode_wb_param #(
  parameter int          DATA_W  = 64,
  parameter int          NREG    = 15,
  parameter int          SP_IDX  = 4,
  parameter int unsigned SP_INIT = 32'd254
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               D_stat,
  input  logic [3:0]               D_icode,
  input  logic [3:0]               D_ifun,
  input  logic [3:0]               D_rA,
  input  logic [3:0]               D_rB,
  input  logic [DATA_W-1:0]        D_valC,
  input  logic [DATA_W-1:0]        D_valP,
  input  logic [3:0]               e_dstE,
  input  logic [DATA_W-1:0]        e_valE,
  input  logic [3:0]               M_dstE,
  input  logic [DATA_W-1:0]        M_valE,
  input  logic [3:0]               M_dstM,
  input  logic [DATA_W-1:0]        m_valM,
  input  logic [3:0]               W_dstE,
  input  logic [DATA_W-1:0]        W_valE,
  input  logic [3:0]               W_dstM,
  input  logic [DATA_W-1:0]        W_valM,
  input  logic                     E_stall,
  input  logic                     E_bubble,
  output logic [3:0]               d_srcA,
  output logic [3:0]               d_srcB,
  output logic [DATA_W-1:0]        d_valA,
  output logic [DATA_W-1:0]        d_valB,
  output logic                     load_use,
  output logic [3:0]               E_stat,
  output logic [3:0]               E_icode,
  output logic [3:0]               E_ifun,
  output logic [3:0]               E_dstE,
  output logic [3:0]               E_dstM,
  output logic [3:0]               E_srcA,
  output logic [3:0]               E_srcB,
  output logic [DATA_W-1:0]        E_valC,
  output logic [DATA_W-1:0]        E_valA,
  output logic [DATA_W-1:0]        E_valB,
  output logic [NREG*DATA_W-1:0]   reg_dump
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]              fwd_cnt,
  output logic [31:0]              bubble_cnt
`endif
);

  localparam logic [3:0]        NONE   = 4'hF;
  localparam logic [3:0]        SP     = 4'(SP_IDX);
  localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);
  localparam logic [DATA_W-1:0] ZERO   = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    logic [DATA_W-1:0] v;
    v = ZERO;
    for (int i = 0; i < NREG; i++) begin
      if (idx == 4'(i)) v = regs[i];
    end
    return v;
  endfunction

  // Priority order is youngest producer first; an unused source (F) never matches.
  function automatic logic [DATA_W-1:0] fwd_val(input logic [3:0] src, input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    if (src == NONE)         v = rf_val;
    else if (src == e_dstE)  v = e_valE;
    else if (src == M_dstM)  v = m_valM;
    else if (src == M_dstE)  v = M_valE;
    else if (src == W_dstM)  v = W_valM;
    else if (src == W_dstE)  v = W_valE;
    else                     v = rf_val;
    return v;
  endfunction

  always_comb begin
    d_srcA = NONE;
    d_srcB = NONE;
    dst_e  = NONE;
    dst_m  = NONE;
    case (D_icode)
      4'h2, 4'h4, 4'h6, 4'hA: d_srcA = D_rA;
      4'h9, 4'hB:             d_srcA = SP;
      default:                d_srcA = NONE;
    endcase
    case (D_icode)
      4'h4, 4'h5, 4'h6:       d_srcB = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: d_srcB = SP;
      default:                d_srcB = NONE;
    endcase
    case (D_icode)
      4'h2, 4'h3, 4'h6:       dst_e = D_rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = SP;
      default:                dst_e = NONE;
    endcase
    case (D_icode)
      4'h5, 4'hB:             dst_m = D_rA;
      default:                dst_m = NONE;
    endcase
  end

  always_comb begin
    d_valA = ZERO;
    d_valB = fwd_val(d_srcB, rf_read(d_srcB));
    if (D_icode == 4'h7 || D_icode == 4'h8) begin
      d_valA = D_valP;
    end else begin
      d_valA = fwd_val(d_srcA, rf_read(d_srcA));
    end
  end

  always_comb begin
    load_use = 1'b0;
    if ((E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != NONE &&
        (E_dstM == d_srcA || E_dstM == d_srcB)) begin
      load_use = 1'b1;
    end else begin
      load_use = 1'b0;
    end
  end

  // Dual write port; iterating by entry makes out-of-range indices (incl. F) drop naturally and lets valM win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= (i == SP_IDX) ? SP_RST : ZERO;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (W_dstM == 4'(i))      regs[i] <= W_valM;
        else if (W_dstE == 4'(i)) regs[i] <= W_valE;
        else                      regs[i] <= regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) reg_dump[i*DATA_W +: DATA_W] <= (i == SP_IDX) ? SP_RST : ZERO;
      else        reg_dump[i*DATA_W +: DATA_W] <= regs[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || E_bubble) begin
      E_stat  <= 4'b1000;
      E_icode <= 4'h1;
      E_ifun  <= 4'h0;
      E_dstE  <= NONE;
      E_dstM  <= NONE;
      E_srcA  <= NONE;
      E_srcB  <= NONE;
      E_valC  <= ZERO;
      E_valA  <= ZERO;
      E_valB  <= ZERO;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic       hit_a;
  logic       hit_b;
  logic [1:0] fwd_inc;

  // An operand counts as forwarded when any bypass source matches it; valP selection is not a forward.
  always_comb begin
    hit_a = (d_srcA != NONE) && !(D_icode == 4'h7 || D_icode == 4'h8) &&
            (d_srcA == e_dstE || d_srcA == M_dstM || d_srcA == M_dstE ||
             d_srcA == W_dstM || d_srcA == W_dstE);
    hit_b = (d_srcB != NONE) &&
            (d_srcB == e_dstE || d_srcB == M_dstM || d_srcB == M_dstE ||
             d_srcB == W_dstM || d_srcB == W_dstE);
    fwd_inc = {1'b0, hit_a} + {1'b0, hit_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_cnt    <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (!E_bubble && !E_stall) fwd_cnt <= fwd_cnt + {30'd0, fwd_inc};
      if (E_bubble)              bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  // Counters not built: no extra ports or state.
`endif

endmodule

// File: doc/decode_wb_param.md
Name: decode_wb_param

Overview:
- Parametrised successor of the pipeline decode/write-back stage.
- Contains a NREG-entry register file with a synchronous active-low reset and dual write ports (dstE, dstM).
- Provides textbook-priority operand forwarding and load/use hazard detection.
- Contains the D→E pipeline register with both stall and bubble control. Sits between the fetch D register and the execute stage.

Parameters:
- DATA_W, 64, datapath/register width in bits
- NREG, 15, number of architectural registers; indices 0..NREG-1 (NREG ≤ 15)
- SP_IDX, 4, stack-pointer register index
- SP_INIT, 254, reset value of register SP_IDX; all other registers reset to 0

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- D_stat  in  4  fetch status (4'b1000 = AOK)
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decoded fetch fields
- D_valC, D_valP  in  DATA_W each  constant, next PC
- e_dstE / e_valE  in  4 / DATA_W  execute-stage forward source
- M_dstE / M_valE, M_dstM / m_valM  in  4 / DATA_W  memory-stage forward sources
- W_dstE / W_valE, W_dstM / W_valM  in  4 / DATA_W  write-back ports, also forward sources
- E_icode_q_dstM_chk  in  —  none; load/use uses internal E_icode/E_dstM
- E_stall  in  1  hold E register
- E_bubble  in  1  load nop bubble into E register
- d_srcA, d_srcB  out  4 each  combinational source IDs (4'hF = none)
- d_valA, d_valB  out  DATA_W each  combinational forwarded operands
- load_use  out  1  combinational load/use hazard flag
- E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered
- E_valC, E_valA, E_valB  out  DATA_W each  registered
- reg_dump  out  NREG*DATA_W  registered copy of the register file; entry i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Source/destination decode (icode hex):
  - srcA = rA for {2,4,6,A}; srcA = SP_IDX for {9,B}.
  - srcB = rB for {4,5,6}; srcB = SP_IDX for {8,9,A,B}.
  - dstE = rB for {2,3,6}; dstE = SP_IDX for {8,9,A,B}.
  - dstM = rA for {5,B}.
  - Every unused field = 4'hF.
- Register read: combinational. Any index ≥ NREG, including 4'hF, reads 0.
- d_valA priority:
  1. icode ∈ {7,8} → D_valP
  2. srcA == e_dstE → e_valE
  3. M_dstM → m_valM
  4. M_dstE → M_valE
  5. W_dstM → W_valM
  6. W_dstE → W_valE
  7. otherwise register file
  - A match is valid only if the source ≠ 4'hF.
- d_valB: same priority chain, minus step 1.
- load_use: asserted when E_icode ∈ {5,B} and E_dstM ≠ F and E_dstM ∈ {d_srcA, d_srcB}. The flag is combinational and is consumed by external pipeline control.
- Write-back on rising edge:
  - Write W_valE to W_dstE when W_dstE < NREG.
  - Write W_valM to W_dstM when W_dstM < NREG.
  - If W_dstE == W_dstM, W_valM wins.
  - Indices ≥ NREG (other than F) are silently dropped.
- reg_dump: updated every cycle with post-write contents. This gives one cycle of latency after a write.
- E register update, in decreasing priority:
  - rst_n = 0 → bubble state.
  - E_bubble → bubble state.
  - E_stall → hold.
  - Otherwise load the D fields and the decoded/forwarded values.
  - E_bubble and E_stall together → bubble wins.
- Bubble state: E_stat = 4'b1000, E_icode = 1, E_ifun = 0, valC/valA/valB = 0, dstE/dstM/srcA/srcB = 4'hF.
- Reset:
  - Register file cleared; reg[SP_IDX] = SP_INIT.
  - reg_dump reflects the reset values from the next cycle.
  - Write-back is suppressed during the reset cycle.
  - Reset mid-operation discards in-flight E contents.

Optional Feature:
- DECODE_PERF_CNT_EN defined adds outputs fwd_cnt[31:0] and bubble_cnt[31:0]. Both reset to 0.
  - fwd_cnt increments by 0, 1 or 2 per cycle: the number of operands (A, B) taken from a forward source rather than the register file or valP. It counts only when the E register loads, i.e. no stall or bubble.
  - bubble_cnt increments each cycle E_bubble = 1.
  - Both counters wrap at 2^32.
- Undefined: no counters and no extra ports.

Test Plan:
- Reset: rst_n = 0 for one cycle → reg_dump shows reg4 = 254 and others 0; E_icode = 1; E_dstE = F.
- ALU forwarding: D = opq (6) rA = 2, rB = 3, with e_dstE = 2, e_valE = 0x55 and M_dstE = 3, M_valE = 0x77 → d_valA = 0x55, d_valB = 0x77; E_valA = 0x55 next cycle.
- Priority chain: srcA = 1 matched by both M_dstM (m_valM = 0xAA) and W_dstE (W_valE = 0xBB) → d_valA = 0xAA.
- Load/use: E holds mrmovq (5) with E_dstM = 2, D = opq rA = 2 → load_use = 1. With E_stall = 1 the E register holds; with E_bubble = 1, E_icode = 1 next cycle.
- Dual write conflict: W_dstE = W_dstM = 4, W_valE = 0x10, W_valM = 0x20 → reg_dump reg4 = 0x20.
- call (8): D_valP = 0x40 → d_valA = 0x40, d_srcB = 4, E_dstE = 4; with DECODE_PERF_CNT_EN and no forward match, fwd_cnt stays unchanged.
